// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch, data) in front of a
// single shared memory port with a fixed read latency of MEM_LAT cycles.
//
// Optional feature macro: MEM_ARB_FAIR_EN
//   defined   -> starvation counter lets fetch win one simultaneous arbitration
//                after STARVE_MAX consecutive data grants made while fetch waited
//   undefined -> strict data-over-fetch priority
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 fetch request and byte address
//   if_data/if_done/if_stall       fetch read data, completion pulse, hold
//   dm_req/dm_wr/dm_addr/dm_wdata  data request, write flag, address, write data
//   dm_rdata/dm_done/dm_stall      data read value, completion pulse, hold
//   mem_enable/mem_wr/mem_addr/mem_wdata  shared memory command (one cycle)
//   mem_rdata                      shared memory read data
//   err                            sticky alignment / protocol error
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_data,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned DW    = 16;
  localparam logic [CNT_W-1:0] LAT_DONE   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Elaboration-time parameter range checks
  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
    $error("mem_arbiter: MEM_LAT must be 1..7");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be 1..7");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             acc_wr_q, acc_wr_d;
  logic             mem_enable_d, mem_wr_d;
  logic [DW-1:0]    mem_addr_d, mem_wdata_d;
  logic             if_done_d, dm_done_d;
  logic [DW-1:0]    if_data_d, dm_rdata_d;
  logic             err_d;
  logic             fetch_first;
  logic             grant_dm;

`ifdef MEM_ARB_FAIR_EN
  logic [CNT_W-1:0] starve_q, starve_d;
  // Fetch takes priority once data has been granted STARVE_MAX times over it
  assign fetch_first = (starve_q == STARVE_LIM);
`else
  assign fetch_first = 1'b0;
`endif

  assign grant_dm = dm_req & ~(if_req & fetch_first);

  // Requester must hold its request until its done pulse
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    acc_wr_d     = acc_wr_q;
    mem_enable_d = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    if_data_d    = if_data;
    dm_rdata_d   = dm_rdata;
    err_d        = err;
`ifdef MEM_ARB_FAIR_EN
    starve_d     = starve_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d      = BUSY_DM;
          lat_d        = CNT_W'(1);
          acc_wr_d     = dm_wr;
          mem_enable_d = 1'b1;
          mem_wr_d     = dm_wr;
          mem_addr_d   = {dm_addr[DW-1:1], 1'b0};
          mem_wdata_d  = dm_wr ? dm_wdata : '0;
          if (dm_addr[0]) err_d = 1'b1;
`ifdef MEM_ARB_FAIR_EN
          if (if_req && (starve_q != STARVE_LIM)) starve_d = starve_q + CNT_W'(1);
`endif
        end else if (if_req) begin
          state_d      = BUSY_IF;
          lat_d        = CNT_W'(1);
          acc_wr_d     = 1'b0;
          mem_enable_d = 1'b1;
          mem_addr_d   = {if_addr[DW-1:1], 1'b0};
          if (if_addr[0]) err_d = 1'b1;
`ifdef MEM_ARB_FAIR_EN
          starve_d     = '0;
`endif
        end
      end

      BUSY_IF: begin
        if (!if_req) err_d = 1'b1;
        if (lat_q == LAT_DONE) begin
          state_d   = IDLE;
          if_done_d = 1'b1;
          if_data_d = mem_rdata;
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end

      BUSY_DM: begin
        if (!dm_req) err_d = 1'b1;
        if (lat_q == LAT_DONE) begin
          state_d   = IDLE;
          dm_done_d = 1'b1;
          // Writes leave the last read value visible
          if (!acc_wr_q) dm_rdata_d = mem_rdata;
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      acc_wr_q   <= 1'b0;
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      if_data    <= '0;
      dm_rdata   <= '0;
      err        <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      acc_wr_q   <= acc_wr_d;
      mem_enable <= mem_enable_d;
      mem_wr     <= mem_wr_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      if_done    <= if_done_d;
      dm_done    <= dm_done_d;
      if_data    <= if_data_d;
      dm_rdata   <= dm_rdata_d;
      err        <= err_d;
`ifdef MEM_ARB_FAIR_EN
      starve_q   <= starve_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (MEM_LAT=2, STARVE_MAX=3) with a small
// behavioural memory that returns read data one cycle after the command.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_done;
  logic        if_stall;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        err;

  int tests_run = 0;
  int failed    = 0;

  logic [15:0] mem_model [0:255];

  mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_data    (if_data),
    .if_done    (if_done),
    .if_stall   (if_stall),
    .dm_req     (dm_req),
    .dm_wr      (dm_wr),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_done    (dm_done),
    .dm_stall   (dm_stall),
    .mem_enable (mem_enable),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Memory: command seen in cycle G, read data presented in cycle G+1
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_wr) mem_model[mem_addr[8:1]] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr[8:1]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int data_grants;
  int fetch_grants;
  int grant_no;
  int first_fetch;

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 16'(i * 3);
    mem_model[8'h08] = 16'hABCD;  // 0x0010
    mem_model[8'h20] = 16'h5555;  // 0x0040
    mem_model[8'h18] = 16'h7777;  // 0x0030

    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    tick(); tick();

    // Reset state
    check("rst mem_enable", 16'(mem_enable), 16'h0);
    check("rst mem_wr",     16'(mem_wr),     16'h0);
    check("rst mem_addr",   mem_addr,        16'h0);
    check("rst mem_wdata",  mem_wdata,       16'h0);
    check("rst if_done",    16'(if_done),    16'h0);
    check("rst dm_done",    16'(dm_done),    16'h0);
    check("rst if_data",    if_data,         16'h0);
    check("rst dm_rdata",   dm_rdata,        16'h0);
    check("rst err",        16'(err),        16'h0);
    rst = 1'b0;
    tick();

    // Single fetch read
    if_req = 1'b1; if_addr = 16'h0010;
    tick();  // G
    check("f mem_enable G", 16'(mem_enable), 16'h1);
    check("f mem_addr G",   mem_addr,        16'h0010);
    check("f mem_wr G",     16'(mem_wr),     16'h0);
    check("f if_stall G",   16'(if_stall),   16'h1);
    tick();  // G+1
    check("f mem_enable G+1", 16'(mem_enable), 16'h0);
    check("f if_done G+1",    16'(if_done),    16'h0);
    check("f if_stall G+1",   16'(if_stall),   16'h1);
    tick();  // G+2
    check("f if_done G+2",  16'(if_done),  16'h1);
    check("f if_data G+2",  if_data,       16'hABCD);
    check("f if_stall G+2", 16'(if_stall), 16'h0);
    if_req = 1'b0;
    tick();
    check("f if_done G+3",    16'(if_done),    16'h0);
    check("f mem_enable G+3", 16'(mem_enable), 16'h0);

    // Simultaneous requests: data first, then fetch
    if_req = 1'b1; if_addr = 16'h0030;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0040;
    tick();  // G
    check("both mem_addr G", mem_addr,        16'h0040);
    check("both dm_stall G", 16'(dm_stall),   16'h1);
    tick();  // G+1
    tick();  // G+2
    check("both dm_done G+2",  16'(dm_done),  16'h1);
    check("both dm_rdata G+2", dm_rdata,      16'h5555);
    check("both if_stall G+2", 16'(if_stall), 16'h1);
    dm_req = 1'b0;
    tick();  // G+3
    check("both fetch grant G+3", 16'(mem_enable), 16'h1);
    check("both fetch addr G+3",  mem_addr,        16'h0030);
    tick();  // G+4
    check("both if_done G+4", 16'(if_done), 16'h0);
    tick();  // G+5
    check("both if_done G+5", 16'(if_done), 16'h1);
    check("both if_data G+5", if_data,      16'h7777);
    if_req = 1'b0;
    tick();

    // Data write
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    tick();  // G
    check("wr mem_wr G",    16'(mem_wr), 16'h1);
    check("wr mem_wdata G", mem_wdata,   16'h1234);
    check("wr mem_addr G",  mem_addr,    16'h0020);
    tick();  // G+1
    check("wr mem_wr G+1",    16'(mem_wr), 16'h0);
    check("wr mem_wdata G+1", mem_wdata,   16'h0000);
    tick();  // G+2
    check("wr dm_done G+2",  16'(dm_done), 16'h1);
    check("wr dm_rdata G+2", dm_rdata,     16'h5555);
    dm_req = 1'b0; dm_wr = 1'b0;
    tick();

    // Both requests held continuously for 24 cycles
    if_req = 1'b1; if_addr = 16'h0002;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0004;
    data_grants = 0; fetch_grants = 0; grant_no = 0; first_fetch = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (mem_enable) begin
        grant_no++;
        if (mem_addr == 16'h0002) begin
          fetch_grants++;
          if (first_fetch == 0) first_fetch = grant_no;
        end else begin
          data_grants++;
        end
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
`ifdef MEM_ARB_FAIR_EN
    check("starve first fetch grant", 16'(first_fetch),  16'd4);
    check("starve fetch grants",      16'(fetch_grants), 16'd2);
    check("starve data grants",       16'(data_grants),  16'd6);
`else
    check("strict fetch grants", 16'(fetch_grants), 16'd0);
    check("strict data grants",  16'(data_grants),  16'd8);
`endif
    tick();
    check("held err clear", 16'(err), 16'h0);

    // Reset in the middle of a data read
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0040;
    tick();  // G
    check("rstmid grant G", 16'(mem_enable), 16'h1);
    tick();  // G+1
    rst = 1'b1;
    tick();  // G+2
    check("rstmid dm_done",    16'(dm_done),    16'h0);
    check("rstmid dm_rdata",   dm_rdata,        16'h0);
    check("rstmid if_data",    if_data,         16'h0);
    check("rstmid mem_enable", 16'(mem_enable), 16'h0);
    check("rstmid mem_addr",   mem_addr,        16'h0);
    rst = 1'b0;
    tick();  // new G
    check("rstmid regrant",      16'(mem_enable), 16'h1);
    check("rstmid regrant addr", mem_addr,        16'h0040);
    tick();
    check("rstmid no early done", 16'(dm_done), 16'h0);
    tick();
    check("rstmid dm_done", 16'(dm_done), 16'h1);
    check("rstmid rdata",   dm_rdata,     16'h5555);
    dm_req = 1'b0;
    tick();

    // Misaligned data read
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0011;
    tick();  // G
    check("mis mem_addr G", mem_addr, 16'h0010);
    check("mis err G",      16'(err), 16'h1);
    tick();
    tick();  // G+2
    check("mis dm_done", 16'(dm_done), 16'h1);
    check("mis dm_rdata", dm_rdata,    16'hABCD);
    dm_req = 1'b0;
    tick(); tick(); tick();
    check("mis err sticky", 16'(err), 16'h1);
    rst = 1'b1;
    tick();
    check("mis err cleared", 16'(err), 16'h0);
    rst = 1'b0;
    tick();

    // Fetch drops its request while in flight
    if_req = 1'b1; if_addr = 16'h0010;
    tick();  // G
    check("drop err G", 16'(err), 16'h0);
    if_req = 1'b0;
    tick();  // G+1
    check("drop err G+1", 16'(err), 16'h1);
    tick();  // G+2
    check("drop if_done", 16'(if_done), 16'h1);
    check("drop if_data", if_data,      16'hABCD);
    tick();
    check("drop err sticky", 16'(err), 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory read latency in cycles (legal 1..7).
REQ-002 Parameter STARVE_MAX, default 3, consecutive data grants tolerated while fetch waits (legal 1..7).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  fetch requester access request.
REQ-006 if_addr  input  16  fetch byte address.
REQ-007 if_data  output  16  fetch read data, valid while if_done=1.
REQ-008 if_done  output  1  one-cycle fetch completion pulse.
REQ-009 if_stall  output  1  fetch must hold its request.
REQ-010 dm_req  input  1  data requester access request.
REQ-011 dm_wr  input  1  data access is a write (1) or read (0).
REQ-012 dm_addr  input  16  data byte address.
REQ-013 dm_wdata  input  16  data write value.
REQ-014 dm_rdata  output  16  data read value, valid while dm_done=1.
REQ-015 dm_done  output  1  one-cycle data completion pulse.
REQ-016 dm_stall  output  1  data requester must hold its request.
REQ-017 mem_enable, mem_wr  output  1 each  shared memory port controls.
REQ-018 mem_addr, mem_wdata  output  16 each  shared memory address and write data.
REQ-019 mem_rdata  input  16  shared memory read data.
REQ-020 err  output  1  sticky protocol/alignment error flag.

Function
REQ-021 FSM states IDLE, BUSY_IF, BUSY_DM; IDLE->BUSY_x on grant, BUSY_x->IDLE in the completion cycle.
REQ-022 In IDLE, a request sampled at a rising edge produces grant cycle G (the next cycle): mem_enable=1 for exactly cycle G, with mem_addr/mem_wr/mem_wdata latched from the winning requester.
REQ-023 Fetch grants drive mem_wr=0 and mem_wdata=0.
REQ-024 Memory presents mem_rdata in cycle G+MEM_LAT-1; the arbiter registers it, and x_done=1 and x_data/x_rdata are valid in cycle G+MEM_LAT.
REQ-025 Writes complete identically (dm_done at G+MEM_LAT); dm_rdata holds its previous value.
REQ-026 If both requests are high in IDLE, data wins unless the fairness rule (REQ-035) applies.
REQ-027 Requests arriving in BUSY states are not granted until IDLE; earliest back-to-back grant is G+MEM_LAT+1.
REQ-028 x_stall = x_req AND NOT x_done, combinational.
REQ-029 Address bit 0 set at grant -> err set; the access proceeds with mem_addr bit 0 forced to 0.
REQ-030 Requester deasserting req while its access is in flight -> err set; the access still completes and the done pulse is issued.
REQ-031 err, once set, stays 1 until rst.
REQ-032 Latency counter is 3 bits wide and never wraps: it loads at grant and stops at MEM_LAT.

Reset
REQ-033 rst=1 at an edge -> next cycle: state IDLE; all outputs 0 (mem_*, x_done, x_data, x_rdata, err); latency and starvation counters 0.
REQ-034 Reset mid-access abandons the access: no done pulse is ever issued for it, and the request must be re-presented.

Configuration
REQ-035 With MEM_ARB_FAIR_EN defined: a starvation counter increments on each data grant made while if_req=1, clears on each fetch grant, and fetch wins the next simultaneous arbitration once it equals STARVE_MAX.
REQ-036 Without MEM_ARB_FAIR_EN: strict data priority, no starvation counter logic.

Verification
REQ-037 MEM_LAT=2; if_req with if_addr=0x0010; memory returns 0xABCD -> mem_enable at G with mem_addr=0x0010, if_done at G+2 with if_data=0xABCD, if_stall=1 through G+1.
REQ-038 if_req and dm_req (read, 0x0040) rise together -> data granted at G with mem_addr=0x0040, dm_done at G+2, fetch granted at G+3, if_done at G+5.
REQ-039 dm write 0x1234 to 0x0020 -> mem_wr=1 and mem_wdata=0x1234 for one cycle only, dm_done at G+2, dm_rdata unchanged.
REQ-040 dm_req and if_req held high continuously, STARVE_MAX=3: with MEM_ARB_FAIR_EN, the 4th grant goes to fetch; without it, no fetch grant occurs over 20 cycles.
REQ-041 rst asserted during G+1 of a read -> no dm_done pulse; all outputs 0 the next cycle; a new request is granted normally afterward.
REQ-042 dm read at 0x0011 -> err=1, mem_addr=0x0010, access completes normally; err stays 1 until rst.
